// File: rtl/computer_8bit.sv
// SAP-1 style 8-bit computer: 16x8 RAM, A/B/OUT registers, carry/zero flags.
// Every instruction runs five micro-steps; the built-in program counts OUT 0..255, then halts.
module computer_8bit (
   input  logic        CLOCK_50,
   input  logic [3:0]  KEY,
   output logic [17:0] LEDR,
   output logic [8:0]  LEDG
);

   typedef enum logic [2:0] {T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4} step_t;

   logic       rst;
   logic       unused_keys;
   step_t      step_reg, step_next;
   logic [3:0] pc_reg, mar_reg;
   logic [7:0] ir_reg, a_reg, b_reg, out_reg;
   logic       c_reg, z_reg, halt_reg;
   logic [7:0] mem [16];

   logic [3:0] op, n;
   logic [7:0] ram_data, b_operand;
   logic [8:0] alu_sum;

   logic mar_from_pc, ir_load, pc_inc, mar_from_n, a_from_ram, b_from_ram;
   logic alu_to_a, alu_sub, ram_write, a_from_imm, pc_jump, out_load, halt_set;

   assign rst         = KEY[0];
   assign unused_keys = ^KEY[3:1];
   assign op          = ir_reg[7:4];
   assign n           = ir_reg[3:0];
   assign ram_data    = mem[mar_reg];

   // The reset image doubles as the program ROM.
   function automatic logic [7:0] image_byte(input logic [3:0] addr);
      case (addr)
         4'd0:    image_byte = 8'h50;
         4'd1:    image_byte = 8'hE0;
         4'd2:    image_byte = 8'h2F;
         4'd3:    image_byte = 8'h75;
         4'd4:    image_byte = 8'h61;
         4'd5:    image_byte = 8'hF0;
         4'd15:   image_byte = 8'h01;
         default: image_byte = 8'h00;
      endcase
   endfunction

   always_ff @(posedge CLOCK_50 or posedge rst) begin
      if (rst) begin
         step_reg <= T0;
      end else if (!halt_reg) begin
         step_reg <= step_next;
      end
   end

   always_comb begin
      step_next = T0;
      case (step_reg)
         T0:      step_next = T1;
         T1:      step_next = T2;
         T2:      step_next = T3;
         T3:      step_next = T4;
         default: step_next = T0;
      endcase
   end

   always_comb begin
      mar_from_pc = 1'b0;
      ir_load     = 1'b0;
      pc_inc      = 1'b0;
      mar_from_n  = 1'b0;
      a_from_ram  = 1'b0;
      b_from_ram  = 1'b0;
      alu_to_a    = 1'b0;
      alu_sub     = 1'b0;
      ram_write   = 1'b0;
      a_from_imm  = 1'b0;
      pc_jump     = 1'b0;
      out_load    = 1'b0;
      halt_set    = 1'b0;
      case (step_reg)
         T0: mar_from_pc = 1'b1;
         T1: begin
            ir_load = 1'b1;
            pc_inc  = 1'b1;
         end
         T2: begin
            case (op)
               4'h1, 4'h2, 4'h3, 4'h4: mar_from_n = 1'b1;
               4'h5:    a_from_imm = 1'b1;
               4'h6:    pc_jump    = 1'b1;
               4'h7:    pc_jump    = c_reg;
               4'h8:    pc_jump    = z_reg;
               4'hE:    out_load   = 1'b1;
               4'hF:    halt_set   = 1'b1;
               default: ;
            endcase
         end
         T3: begin
            case (op)
               4'h1:       a_from_ram = 1'b1;
               4'h2, 4'h3: b_from_ram = 1'b1;
               4'h4:       ram_write  = 1'b1;
               default:    ;
            endcase
         end
         T4: begin
            alu_to_a = (op == 4'h2) || (op == 4'h3);
            alu_sub  = (op == 4'h3);
         end
         default: ;
      endcase
   end

   // Subtraction is A + ~B + 1, so carry-out set means "no borrow".
   assign b_operand = alu_sub ? ~b_reg : b_reg;
   assign alu_sum   = {1'b0, a_reg} + {1'b0, b_operand} + {8'd0, alu_sub};

   always_ff @(posedge CLOCK_50 or posedge rst) begin
      if (rst) begin
         pc_reg   <= 4'd0;
         mar_reg  <= 4'd0;
         ir_reg   <= 8'd0;
         a_reg    <= 8'd0;
         b_reg    <= 8'd0;
         out_reg  <= 8'd0;
         c_reg    <= 1'b0;
         z_reg    <= 1'b0;
         halt_reg <= 1'b0;
         for (int i = 0; i < 16; i++) mem[i] <= image_byte(4'(i));
      end else if (!halt_reg) begin
         if (mar_from_pc) mar_reg <= pc_reg;
         if (mar_from_n)  mar_reg <= n;
         if (ir_load)     ir_reg  <= ram_data;
         if (pc_inc)      pc_reg  <= pc_reg + 4'd1;
         if (pc_jump)     pc_reg  <= n;
         if (a_from_ram)  a_reg   <= ram_data;
         if (a_from_imm)  a_reg   <= {4'h0, n};
         if (b_from_ram)  b_reg   <= ram_data;
         if (out_load)    out_reg <= a_reg;
         if (ram_write)   mem[mar_reg] <= a_reg;
         if (halt_set)    halt_reg <= 1'b1;
         if (alu_to_a) begin
            a_reg <= alu_sum[7:0];
            c_reg <= alu_sum[8];
            z_reg <= (alu_sum[7:0] == 8'd0);
         end
      end
   end

   assign LEDR = {z_reg, c_reg, a_reg, out_reg};
   assign LEDG = {halt_reg, 1'b0, step_reg, pc_reg};

endmodule

// File: tb/tb_computer_8bit.sv
// Randomised reset/run episodes; an instruction-level model predicts the visible state
// at instruction boundaries, and a monitor compares DUT outputs against the queued predictions.
module tb_computer_8bit;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  junk;
   logic [3:0]  key;
   logic [17:0] ledr;
   logic [8:0]  ledg;

   assign key = {junk, rst};

   always #10 clk = ~clk;

   computer_8bit dut (
      .CLOCK_50(clk),
      .KEY     (key),
      .LEDR    (ledr),
      .LEDG    (ledg)
   );

   typedef struct {
      int          edge_no;
      logic [17:0] ledr;
      logic [8:0]  ledg;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   edge_cnt;

   // Rising edges since reset release.
   always @(posedge clk or posedge rst) begin
      if (rst) edge_cnt <= 0;
      else     edge_cnt <= edge_cnt + 1;
   end

   function automatic logic [7:0] prog_byte(input int addr);
      case (addr)
         0: prog_byte = 8'h50;
         1: prog_byte = 8'hE0;
         2: prog_byte = 8'h2F;
         3: prog_byte = 8'h75;
         4: prog_byte = 8'h61;
         5: prog_byte = 8'hF0;
         15: prog_byte = 8'h01;
         default: prog_byte = 8'h00;
      endcase
   endfunction

   task automatic push_exp(input int e, input logic [3:0] pc, input logic [2:0] st,
                           input logic [7:0] a, input logic [7:0] out,
                           input logic c, input logic z, input logic h);
      exp_t x;
      x.edge_no = e;
      x.ledr    = {z, c, a, out};
      x.ledg    = {h, 1'b0, st, pc};
      sb.push_back(x);
   endtask

   // Interpret the program one whole instruction at a time; each instruction occupies
   // five edges, so its results are visible after edge 5k+5 (HLT takes effect at 5k+3).
   task automatic plan_episode(input int run_len);
      logic [7:0] m [16];
      logic [3:0] pc, n;
      logic [7:0] a, out, ir, opnd;
      logic       c, z, h;
      int         sum;
      for (int i = 0; i < 16; i++) m[i] = prog_byte(i);
      pc = 0; a = 0; out = 0; c = 0; z = 0; h = 0;
      push_exp(0, 4'd0, 3'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
      push_exp(0, 4'd0, 3'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
      if (run_len >= 2) push_exp(2, 4'd1, 3'd2, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
      for (int start = 0; start + 3 <= run_len; start += 5) begin
         ir = m[pc];
         pc = pc + 4'd1;
         n  = ir[3:0];
         case (ir[7:4])
            4'h1: a = m[n];
            4'h2: begin
               sum = int'(a) + int'(m[n]);
               a = sum[7:0]; c = (sum > 255); z = (a == 0);
            end
            4'h3: begin
               opnd = ~m[n];
               sum = int'(a) + int'(opnd) + 1;
               a = sum[7:0]; c = (sum > 255); z = (a == 0);
            end
            4'h4: m[n] = a;
            4'h5: a = {4'h0, n};
            4'h6: pc = n;
            4'h7: if (c) pc = n;
            4'h8: if (z) pc = n;
            4'hE: out = a;
            4'hF: h = 1'b1;
            default: ;
         endcase
         if (h) begin
            for (int f = start + 3; f <= run_len; f += 997)
               push_exp(f, pc, 3'd3, a, out, c, z, 1'b1);
            break;
         end
         if (start + 5 <= run_len) push_exp(start + 5, pc, 3'd0, a, out, c, z, 1'b0);
      end
   endtask

   initial begin
      int rlen, run_len;
      rst  = 1'b0;
      junk = 3'd0;

      fork
         forever begin
            exp_t e;
            @(negedge clk or posedge rst);
            #1;
            if (sb.size() > 0) begin
               if (sb[0].edge_no == edge_cnt) begin
                  e = sb.pop_front();
                  n_checks++;
                  if (ledr !== e.ledr || ledg !== e.ledg) begin
                     n_fail++;
                     $display("FAIL state@edge%0d: ledr=%h ledg=%h, expected ledr=%h ledg=%h",
                              e.edge_no, ledr, ledg, e.ledr, e.ledg);
                  end
               end else if (sb[0].edge_no < edge_cnt) begin
                  e = sb.pop_front();
                  n_checks++;
                  n_fail++;
                  $display("FAIL missed@edge%0d: now at edge %0d, expected ledr=%h ledg=%h",
                           e.edge_no, edge_cnt, e.ledr, e.ledg);
               end
            end
         end
      join_none

      repeat (2) @(negedge clk);
      #3;
      for (int ep = 0; ep < 6; ep++) begin
         case (ep)
            0: begin rlen = 50; run_len = 1000;  end
            1: begin rlen = 3;  run_len = 45200; end
            default: begin
               rlen    = $urandom_range(1, 20);
               run_len = $urandom_range(3, 2500);
            end
         endcase
         plan_episode(run_len);
         $display("episode %0d: reset %0d clocks, run %0d edges, %0d expectations queued",
                  ep, rlen, run_len, sb.size());
         rst = 1'b1;
         repeat (rlen) begin
            @(negedge clk);
            #2 junk = 3'($urandom);
         end
         rst = 1'b0;
         repeat (run_len) begin
            @(posedge clk);
            #2 junk = 3'($urandom);
         end
         @(negedge clk);
         #3;
         if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
            sb.delete();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
